apx_err_monitor: RTL and testbench
==================================

# apx_err_monitor

Streaming error-statistics collector for the approximate integer adders: consumes pairs of results (accurate adder output, approximate adder output) over a valid/ready stream. Over a window of N_SAMPLES accepted pairs it accumulates four statistics: sample count, mismatch count, signed error sum and absolute error sum, plus the maximum absolute error. It then presents one report on a valid/ready output and starts a new window. It is the receive/checking end of the adder stimulus path, giving on-chip bias and accuracy figures per approximation setting.

## Interface
- WIDTH, 32, operand/result width; both results are signed two's complement
- N_SAMPLES, 500, pairs per report window, ≥ 1
- CNT_W, $clog2(N_SAMPLES+1), counter width (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous window abort/clear
- in_valid  in  1  result pair valid
- in_ready  out  1  monitor accepts pair
- acc_c  in  WIDTH  accurate adder result
- apx_c  in  WIDTH  approximate adder result
- rpt_valid  out  1  report available
- rpt_ready  in  1  report consumed
- rpt_count  out  CNT_W  pairs in window (= N_SAMPLES unless aborted)
- rpt_mismatch  out  CNT_W  pairs with acc_c != apx_c
- rpt_sum_err  out  WIDTH+1+CNT_W  signed Σ(acc_c − apx_c)
- rpt_sum_abs  out  WIDTH+CNT_W  unsigned Σ|acc_c − apx_c|
- rpt_max_abs  out  WIDTH  unsigned max |acc_c − apx_c|

## Operation
- Error: d = sext(acc_c) − sext(apx_c) in WIDTH+1 bits (never overflows). |d| ≤ 2^WIDTH − 1, so it fits WIDTH bits unsigned. Mismatch iff d != 0.
- Sums cannot overflow at these widths; no saturation logic.
- Stage 1 registers d and |d|. Stage 2 adds them into the accumulators, increments the mismatch counter when d != 0, and updates max when |d| > max (strict).
- FSM states:
  - COLLECT: in_ready=1. Each accept increments the window count. The accept that brings the count to N_SAMPLES moves to DRAIN.
  - DRAIN: in_ready=0. Lasts exactly 1 cycle, then moves to REPORT.
  - REPORT: in_ready=0, rpt_valid=1. When rpt_valid && rpt_ready, zero all accumulators and return to COLLECT.
- in_ready depends only on state, never on in_valid.
- Report fields are the live accumulators. They are stable throughout REPORT because no accepts occur there.
- clr: highest synchronous priority. Flushes stage 1, zeroes all statistics, returns to COLLECT. In REPORT, the pending report is discarded.
- rst (async): state COLLECT, pipeline empty, all statistics 0.

## Timing
- Reset values: in_ready=1, rpt_valid=0, all rpt_* fields 0.
- Throughput: 1 pair/cycle in COLLECT.
- Latency: with E0 the edge accepting the last pair, stage 2 accumulates at E1 and the state becomes REPORT at E1. rpt_valid is high in the cycle after E1.
- No pairs are accepted from E0 until the edge after the report handshake.
- Minimum window period: N_SAMPLES + 2 cycles when rpt_ready is held 1.
- rpt_ready high outside REPORT is ignored.
- clr together with an accept or a report handshake: clr wins. Neither the pair nor the report is counted or consumed.
- rst mid-window: all partial statistics are lost, and no report is emitted for that window.

## Structure
- Package apx_err_pkg holds:
  - the state enum (ST_COLLECT, ST_DRAIN, ST_REPORT);
  - width functions for the count, signed-sum and absolute-sum widths.
- Sub-module apx_err_diff_stage computes the stage-1 register: sign-extended subtract, absolute value, nonzero flag, and valid bit, with clear input.
- Top level holds the FSM, accumulators and report outputs.

## Test plan
- Reset/idle: assert rst mid-cycle → in_ready=1, rpt_valid=0 and all fields 0 immediately (async), before any clock edge.
- Exact window, N_SAMPLES=4: pairs (5,5), (7,6), (−3,1), (0x7FFFFFFF,0x80000000) → count=4, mismatch=3, sum_err=1−4+(2^32−1)=2^32−4, sum_abs=1+4+(2^32−1)=2^32+4, max_abs=0xFFFFFFFF. rpt_valid is high in the cycle after the edge following the last accept.
- Backpressure: rpt_ready=0 for 10 cycles → in_ready=0 and fields stable. Then rpt_ready=1 → the next cycle has in_ready=1 and all fields 0.
- Throttled input: in_valid toggling 1/0 for a window of all-equal pairs → mismatch=0, sum_abs=0, max_abs=0, exactly one report.
- clr during COLLECT after 2 of 4 pairs, then 4 pairs of error +2 → report count=4, sum_err=8. clr in REPORT → report dropped, no handshake required.
- Back-to-back windows, rpt_ready=1 constant, in_valid=1 constant, 12 pairs with N_SAMPLES=4 → 3 reports, each N_SAMPLES+2=6 cycles apart.

Source files
------------

// File: rtl/apx_err_pkg.sv
// Shared state encoding and width helpers for the approximate-adder error monitor.
package apx_err_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_REPORT  = 2'd2
  } apx_err_state_e;

  function automatic int cnt_w(input int n_samples);
    return $clog2(n_samples + 1);
  endfunction

  // Signed sum needs one extra bit over the magnitude sum for the sign.
  function automatic int sum_w(input int width, input int n_samples);
    return width + 1 + cnt_w(n_samples);
  endfunction

  function automatic int abs_w(input int width, input int n_samples);
    return width + cnt_w(n_samples);
  endfunction

endpackage

// File: rtl/apx_err_diff_stage.sv
// Stage 1: registers the sign-extended error, its magnitude and a nonzero flag
// for each accepted pair; clr_i flushes the stage.
module apx_err_diff_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] apx_i,
  output logic             vld_o,
  output logic [WIDTH:0]   diff_o,
  output logic [WIDTH-1:0] abs_o,
  output logic             nz_o
);
  logic [WIDTH:0]   diff_d, diff_q;
  logic [WIDTH-1:0] abs_d, abs_q;
  logic             vld_q, nz_q;

  // |d| < 2^WIDTH, so negating only the low WIDTH bits gives the exact magnitude.
  always_comb begin
    diff_d = {acc_i[WIDTH-1], acc_i} - {apx_i[WIDTH-1], apx_i};
    abs_d  = diff_d[WIDTH] ? (~diff_d[WIDTH-1:0] + WIDTH'(1)) : diff_d[WIDTH-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      diff_q <= '0;
      abs_q  <= '0;
      nz_q   <= 1'b0;
    end else begin
      vld_q <= vld_i & ~clr_i;
      if (vld_i & ~clr_i) begin
        diff_q <= diff_d;
        abs_q  <= abs_d;
        nz_q   <= |diff_d;
      end
    end
  end

  assign vld_o  = vld_q;
  assign diff_o = diff_q;
  assign abs_o  = abs_q;
  assign nz_o   = nz_q;

endmodule

// File: rtl/apx_err_monitor.sv
// Windowed error statistics over accurate/approximate adder result pairs:
// one report per N_SAMPLES accepted pairs, presented on a valid/ready port.
module apx_err_monitor
  import apx_err_pkg::*;
#(
  parameter int  WIDTH     = 32,
  parameter int  N_SAMPLES = 500,
  localparam int CNT_W     = cnt_w(N_SAMPLES),
  localparam int SUM_W     = sum_w(WIDTH, N_SAMPLES),
  localparam int ABS_W     = abs_w(WIDTH, N_SAMPLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] acc_c,
  input  logic [WIDTH-1:0] apx_c,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic [CNT_W-1:0] rpt_mismatch,
  output logic [SUM_W-1:0] rpt_sum_err,
  output logic [ABS_W-1:0] rpt_sum_abs,
  output logic [WIDTH-1:0] rpt_max_abs
);
  apx_err_state_e   state_q, state_d;
  logic             accept, last_accept, rpt_hs;
  logic             s1_vld, s1_nz;
  logic [WIDTH:0]   s1_diff;
  logic [WIDTH-1:0] s1_abs;
  logic [CNT_W-1:0] cnt_q, cnt_d, mis_q, mis_d;
  logic [SUM_W-1:0] sum_err_q, sum_err_d;
  logic [ABS_W-1:0] sum_abs_q, sum_abs_d;
  logic [WIDTH-1:0] max_q, max_d;

  assign accept      = in_valid & in_ready & ~clr;
  assign last_accept = accept & (cnt_q == CNT_W'(N_SAMPLES - 1));
  assign rpt_hs      = rpt_valid & rpt_ready & ~clr;

  apx_err_diff_stage #(.WIDTH(WIDTH)) u_diff (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (clr),
    .vld_i  (accept),
    .acc_i  (acc_c),
    .apx_i  (apx_c),
    .vld_o  (s1_vld),
    .diff_o (s1_diff),
    .abs_o  (s1_abs),
    .nz_o   (s1_nz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_COLLECT;
    end else begin
      case (state_q)
        ST_COLLECT: if (last_accept) state_d = ST_DRAIN;
        ST_DRAIN:   state_d = ST_REPORT;
        ST_REPORT:  if (rpt_ready) state_d = ST_COLLECT;
        default:    state_d = ST_COLLECT;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_COLLECT);
    rpt_valid = (state_q == ST_REPORT);
  end

  // The DRAIN cycle lets the final pair leave stage 1 before the report is shown.
  always_comb begin
    cnt_d     = cnt_q;
    mis_d     = mis_q;
    sum_err_d = sum_err_q;
    sum_abs_d = sum_abs_q;
    max_d     = max_q;
    if (clr || rpt_hs) begin
      cnt_d     = '0;
      mis_d     = '0;
      sum_err_d = '0;
      sum_abs_d = '0;
      max_d     = '0;
    end else begin
      if (accept) cnt_d = cnt_q + CNT_W'(1);
      if (s1_vld) begin
        mis_d     = mis_q + CNT_W'(s1_nz);
        sum_err_d = sum_err_q + {{(SUM_W-WIDTH-1){s1_diff[WIDTH]}}, s1_diff};
        sum_abs_d = sum_abs_q + {{CNT_W{1'b0}}, s1_abs};
        if (s1_abs > max_q) max_d = s1_abs;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      mis_q     <= '0;
      sum_err_q <= '0;
      sum_abs_q <= '0;
      max_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      mis_q     <= mis_d;
      sum_err_q <= sum_err_d;
      sum_abs_q <= sum_abs_d;
      max_q     <= max_d;
    end
  end

  assign rpt_count    = cnt_q;
  assign rpt_mismatch = mis_q;
  assign rpt_sum_err  = sum_err_q;
  assign rpt_sum_abs  = sum_abs_q;
  assign rpt_max_abs  = max_q;

endmodule

// File: tb/tb_apx_err_monitor.sv
// Scoreboard bench for apx_err_monitor with N_SAMPLES=4 and a window-level reference model.
module tb_apx_err_monitor;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int CW = 3;
  localparam int SW = W + 1 + CW;
  localparam int AW = W + CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic rpt_ready = 1'b0;
  logic in_ready, rpt_valid;
  logic [W-1:0]  acc_c = '0;
  logic [W-1:0]  apx_c = '0;
  logic [CW-1:0] rpt_count, rpt_mismatch;
  logic [SW-1:0] rpt_sum_err;
  logic [AW-1:0] rpt_sum_abs;
  logic [W-1:0]  rpt_max_abs;

  typedef struct {
    longint cnt;
    longint mis;
    longint serr;
    longint sabs;
    longint mx;
  } rpt_t;

  rpt_t   exp_q[$];
  longint win_acc[$];
  longint win_apx[$];
  int     hs_cyc[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     due = 0;
  int     nrep = 0;
  int     n_acc = 0;
  bit     pending = 1'b0;

  apx_err_monitor #(.WIDTH(W), .N_SAMPLES(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .acc_c        (acc_c),
    .apx_c        (apx_c),
    .rpt_valid    (rpt_valid),
    .rpt_ready    (rpt_ready),
    .rpt_count    (rpt_count),
    .rpt_mismatch (rpt_mismatch),
    .rpt_sum_err  (rpt_sum_err),
    .rpt_sum_abs  (rpt_sum_abs),
    .rpt_max_abs  (rpt_max_abs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a window is a list of pairs; statistics come straight from the list.
  task automatic add_sample(input longint a, input longint b);
    rpt_t r;
    win_acc.push_back(a);
    win_apx.push_back(b);
    if (win_acc.size() == N) begin
      r = '{cnt: N, mis: 0, serr: 0, sabs: 0, mx: 0};
      foreach (win_acc[i]) begin
        longint d, m;
        d = win_acc[i] - win_apx[i];
        m = (d < 0) ? -d : d;
        if (d != 0) r.mis++;
        r.serr += d;
        r.sabs += m;
        if (m > r.mx) r.mx = m;
      end
      exp_q.push_back(r);
      pending = 1'b1;
      due = cyc + 2;
      win_acc.delete();
      win_apx.delete();
    end
  endtask

  task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] p,
                       input bit rr, input bit c);
    bit rdy_exp, acc_ok;
    @(negedge clk);
    in_valid  = v;
    acc_c     = a;
    apx_c     = p;
    rpt_ready = rr;
    clr       = c;
    rdy_exp   = !pending;
    chk("in_ready", longint'(in_ready), longint'(rdy_exp));
    acc_ok = v && rdy_exp && !c;
    #3;
    if (c) begin
      win_acc.delete();
      win_apx.delete();
      exp_q.delete();
      pending = 1'b0;
    end else if (acc_ok) begin
      n_acc++;
      add_sample(longint'($signed(a)), longint'($signed(p)));
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_count"}, longint'(rpt_count), 0);
    chk({tag, "_mismatch"}, longint'(rpt_mismatch), 0);
    chk({tag, "_sum_err"}, longint'($signed(rpt_sum_err)), 0);
    chk({tag, "_sum_abs"}, longint'(rpt_sum_abs), 0);
    chk({tag, "_max_abs"}, longint'(rpt_max_abs), 0);
  endtask

  // Monitor: rpt_valid timing every cycle, field comparison while a report is shown.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      chk("rpt_valid", longint'(rpt_valid), longint'(pending && (cyc >= due)));
      if (rpt_valid && exp_q.size() > 0) begin
        chk("rpt_count", longint'(rpt_count), exp_q[0].cnt);
        chk("rpt_mismatch", longint'(rpt_mismatch), exp_q[0].mis);
        chk("rpt_sum_err", longint'($signed(rpt_sum_err)), exp_q[0].serr);
        chk("rpt_sum_abs", longint'(rpt_sum_abs), exp_q[0].sabs);
        chk("rpt_max_abs", longint'(rpt_max_abs), exp_q[0].mx);
        if (rpt_ready && !clr) begin
          void'(exp_q.pop_front());
          pending = 1'b0;
          nrep++;
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x, y;
    int base, start;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", longint'(in_ready), 1);
    chk("reset_rpt_valid", longint'(rpt_valid), 0);
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Async reset in the middle of a partial window.
    drive(1, 32'd3, 32'd1, 0, 0);
    drive(1, 32'd9, 32'd2, 0, 0);
    drive(0, 32'd0, 32'd0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("async_rst_in_ready", longint'(in_ready), 1);
    chk("async_rst_rpt_valid", longint'(rpt_valid), 0);
    check_zero("async_rst");
    win_acc.delete();
    win_apx.delete();
    exp_q.delete();
    pending = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed window, held under backpressure.
    drive(1, 32'd5, 32'd5, 0, 0);
    drive(1, 32'd7, 32'd6, 0, 0);
    drive(1, -32'sd3, 32'd1, 0, 0);
    drive(1, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);
    repeat (10) drive(0, 32'd0, 32'd0, 0, 0);
    chk("dir_count", longint'(rpt_count), 4);
    chk("dir_mismatch", longint'(rpt_mismatch), 3);
    chk("dir_sum_err", longint'($signed(rpt_sum_err)), 64'd4294967292);
    chk("dir_sum_abs", longint'(rpt_sum_abs), 64'd4294967300);
    chk("dir_max_abs", longint'(rpt_max_abs), 64'd4294967295);
    drive(0, 32'd0, 32'd0, 1, 0);
    @(negedge clk);
    #2;
    chk("post_hs_in_ready", longint'(in_ready), 1);
    check_zero("post_hs");

    // Throttled input, all pairs equal.
    base = nrep;
    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      drive((i % 2) == 0, x, x, 1, 0);
    end
    repeat (4) drive(0, 32'd0, 32'd0, 1, 0);
    chk("throttle_reports", nrep - base, 1);

    // clr mid-window, then a clean window of error +2.
    drive(1, $urandom, $urandom, 0, 0);
    drive(1, $urandom, $urandom, 0, 0);
    drive(1, $urandom, $urandom, 0, 1);
    for (int i = 0; i < 4; i++) begin
      x = $urandom_range(0, 32'h7FFF_FFF0);
      drive(1, x + 32'd2, x, 0, 0);
    end
    repeat (3) drive(0, 32'd0, 32'd0, 0, 0);
    chk("clr_count", longint'(rpt_count), 4);
    chk("clr_sum_err", longint'($signed(rpt_sum_err)), 8);
    chk("clr_max_abs", longint'(rpt_max_abs), 2);
    base = nrep;
    drive(0, 32'd0, 32'd0, 1, 1);
    repeat (3) drive(0, 32'd0, 32'd0, 0, 0);
    chk("clr_report_dropped", nrep - base, 0);
    check_zero("after_clr");

    // Back-to-back windows with constant valid and ready.
    hs_cyc.delete();
    base = nrep;
    start = n_acc;
    for (int k = 0; k < 40 && (n_acc - start) < 12; k++) begin
      x = rnd_val();
      y = rnd_val();
      drive(1, x, y, 1, 0);
    end
    chk("b2b_accepts", n_acc - start, 12);
    repeat (4) drive(0, 32'd0, 32'd0, 1, 0);
    chk("b2b_reports", nrep - base, 3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap1", hs_cyc[1] - hs_cyc[0], N + 2);
      chk("b2b_gap2", hs_cyc[2] - hs_cyc[1], N + 2);
    end

    // Random soak.
    for (int k = 0; k < 300; k++) begin
      x = rnd_val();
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x + 32'($urandom_range(0, 6)) - 32'd3;
        default: y = rnd_val();
      endcase
      drive($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    repeat (6) drive(0, 32'd0, 32'd0, 1, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
